// File: rtl/exception_rstatus_writer.sv
// ---------------------------------------------------------------------------
// exception_rstatus_writer
//
// Purpose:
//    Turns each accepted overflow exception of the MW-stage instruction into a
//    write of its status code to the status register through a req/ack
//    register-file write port. Up to DEPTH codes are buffered; when the buffer
//    is full and cannot drain this cycle, upstream is stalled. Every accepted
//    exception pulses exc_flush one cycle later so younger instructions can be
//    squashed.
//
// Ports:
//    clock          in   rising-edge clock
//    reset          in   synchronous, active-high reset
//    exc_valid      in   MW-stage instruction valid this cycle
//    add_exc        in   add overflow   (code 1)
//    addi_exc       in   addi overflow  (code 2)
//    sub_exc        in   sub overflow   (code 3)
//    mul_exc        in   mult overflow  (code 4)
//    div_exc        in   div exception  (code 5)
//    stall          out  exception presented but cannot be accepted
//    wr_req         out  write request to the register file
//    wr_ack         in   register file accepted the write this cycle
//    wr_reg         out  destination register, always STATUS_REG
//    wr_data        out  zero-extended code at the head of the buffer
//    exc_flush      out  one-cycle pulse, cycle after an exception is accepted
//    multi_exc_err  out  one-cycle pulse, cycle after an accepted event that
//                        had more than one flag set
//    pending_count  out  number of codes currently buffered
// ---------------------------------------------------------------------------
module exception_rstatus_writer #(
   parameter int STATUS_REG = 30,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 2
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       exc_valid,
   input  logic                       add_exc,
   input  logic                       addi_exc,
   input  logic                       sub_exc,
   input  logic                       mul_exc,
   input  logic                       div_exc,
   output logic                       stall,
   output logic                       wr_req,
   input  logic                       wr_ack,
   output logic [4:0]                 wr_reg,
   output logic [DATA_WIDTH-1:0]      wr_data,
   output logic                       exc_flush,
   output logic                       multi_exc_err,
   output logic [$clog2(DEPTH):0]     pending_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [1:0] OCC_EMPTY   = 2'd0;
   localparam logic [1:0] OCC_PARTIAL = 2'd1;
   localparam logic [1:0] OCC_FULL    = 2'd2;

   logic [4:0]       flags;
   logic [2:0]       code;
   logic             multi;
   logic             ev;
   logic             full;
   logic             pop;
   logic             push;
   logic [2:0]       fifo_mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [1:0]       occ_state;
   logic [1:0]       occ_next;

   // Lowest code wins; clearing the lowest set bit and testing what remains
   // tells us whether more than one flag was raised.
   always_comb begin
      flags = {div_exc, mul_exc, sub_exc, addi_exc, add_exc};
      code  = 3'd0;
      if (add_exc)       code = 3'd1;
      else if (addi_exc) code = 3'd2;
      else if (sub_exc)  code = 3'd3;
      else if (mul_exc)  code = 3'd4;
      else if (div_exc)  code = 3'd5;
      multi = |(flags & (flags - 5'd1));
   end

   // Handshake decode. A pop frees a slot in the same cycle, so a full buffer
   // can still accept a new code if the head is being written.
   always_comb begin
      ev     = exc_valid & (|flags);
      full   = (occ_state == OCC_FULL);
      wr_req = (count != '0);
      pop    = wr_req & wr_ack;
      push   = ev & (~full | pop);
      stall  = ev & full & ~pop;
   end

   always_comb begin
      wr_reg  = 5'(STATUS_REG);
      wr_data = wr_req ? {{(DATA_WIDTH-3){1'b0}}, fifo_mem[rd_ptr]} : '0;
      pending_count = count;
   end

   // Occupancy tracking; FULL is the only state that affects acceptance.
   always_comb begin
      occ_next = occ_state;
      case (occ_state)
         OCC_EMPTY: begin
            if (push) occ_next = OCC_PARTIAL;
         end
         OCC_PARTIAL: begin
            if (push && !pop && count == CNT_W'(DEPTH - 1))
               occ_next = OCC_FULL;
            else if (pop && !push && count == CNT_W'(1))
               occ_next = OCC_EMPTY;
         end
         OCC_FULL: begin
            if (pop && !push) occ_next = OCC_PARTIAL;
         end
         default: occ_next = OCC_EMPTY;
      endcase
   end

   // Pointers, count, occupancy and the post-accept pulses. Reset drops any
   // pending codes without issuing their writes.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         occ_state     <= OCC_EMPTY;
         exc_flush     <= 1'b0;
         multi_exc_err <= 1'b0;
      end else begin
         occ_state     <= occ_next;
         exc_flush     <= push;
         multi_exc_err <= push & multi;
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)
            count <= count + CNT_W'(1);
         else if (pop && !push)
            count <= count - CNT_W'(1);
      end
   end

   // Code storage needs no reset: entries are only visible while counted.
   always_ff @(posedge clock) begin
      if (!reset && push) fifo_mem[wr_ptr] <= code;
   end

endmodule
